fhn_stim_sequencer: RTL
=======================

FHN_STIM_SEQUENCER -- requirements
Module: fhn_stim_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, width of stimulus, membrane and threshold words (signed Q3.12, FRC_BITS=12).
REQ-002 Parameter CNT_W, default 16, width of duration fields and of spike_cnt.
REQ-003 Parameter NP_W, default 8, width of n_pulses.
REQ-004 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous assert, active-low.
REQ-006 Port start  in  1  begin a run; sampled only in IDLE.
REQ-007 Port abort  in  1  terminate a run; ignored in IDLE.
REQ-008 Port amp  in  DATA_W  signed stimulus amplitude for ON phases.
REQ-009 Ports settle_len, on_len, off_len  in  CNT_W each  phase durations in cycles.
REQ-010 Port n_pulses  in  NP_W  number of ON/OFF pulse pairs.
REQ-011 Ports v_th_hi, v_th_lo  in  DATA_W each  signed spike arm/re-arm thresholds.
REQ-012 Port v  in  DATA_W  signed membrane value from the FHN core.
REQ-013 Port i_out  out  DATA_W  signed stimulus to the core's i input.
REQ-014 Port core_rst  out  1  active-high reset to the FHN core.
REQ-015 Port busy  out  1  high in SETTLE, ON, OFF, FIN.
REQ-016 Port done  out  1  one-cycle pulse at normal run completion.
REQ-017 Port spike  out  1  one-cycle pulse per detected spike.
REQ-018 Port spike_cnt  out  CNT_W  spikes counted in current/last run.

Function
REQ-019 States: IDLE, SETTLE, ON, OFF, FIN; all outputs decoded from registers, no combinational input-to-output path.
REQ-020 IDLE: i_out=0, core_rst=1, busy=0; start=1 latches amp, durations, n_pulses, thresholds, clears spike_cnt and pulse counter, arms detector, enters SETTLE next cycle.
REQ-021 start=1 with n_pulses=0: spike_cnt cleared, state stays IDLE, done=1 on the next cycle only.
REQ-022 SETTLE: core_rst=0, i_out=0, lasts max(settle_len,1) cycles, then ON.
REQ-023 ON: i_out=latched amp for max(on_len,1) cycles; pulse counter increments at last ON cycle; then OFF.
REQ-024 OFF: i_out=0 for max(off_len,1) cycles; then FIN if pulse counter = n_pulses, else ON.
REQ-025 FIN: one cycle, i_out=0, done=1, then IDLE (core_rst returns to 1).
REQ-026 start while not IDLE ignored; changes to config inputs during a run have no effect.
REQ-027 abort=1 in any non-IDLE state: IDLE next cycle, no done pulse, spike_cnt held; abort has priority over any phase transition in the same cycle.
REQ-028 Detector active in SETTLE, ON, OFF only: when armed and v >= v_th_hi (signed compare), spike=1 next cycle, disarm, spike_cnt+1.
REQ-029 Disarmed detector re-arms on cycle where v <= v_th_lo; crossing and re-arm never occur in same cycle.
REQ-030 spike_cnt saturates at 2^CNT_W-1; spike still pulses at saturation.
REQ-031 Spike detected on FIN-entry cycle is still counted; none counted in FIN or IDLE.

Reset
REQ-032 rst=0 asynchronously forces IDLE, i_out=0, core_rst=1, busy=0, done=0, spike=0, spike_cnt=0, detector armed, counters 0.
REQ-033 rst=0 mid-run discards the run with no done pulse; operation resumes on first edge after rst=1.

Verification
REQ-034 amp=410, settle=2, on=3, off=4, n=2, start pulse at cycle 0 -> i_out=0 cycles 1-2, 410 cycles 3-5, 0 cycles 6-9, 410 cycles 10-12, 0 cycles 13-16, done=1 cycle 17 only, busy cycles 1-17, core_rst=0 cycles 1-17.
REQ-035 th_hi=4096, th_lo=1024, v sequence 0,5000,5000,5000,0,5000 during run -> exactly 2 spike pulses, spike_cnt=2.
REQ-036 v oscillating 4000/4200 with th_lo=1024 -> 1 spike only (hysteresis holds).
REQ-037 n_pulses=0, start -> no busy, done=1 one cycle later, spike_cnt=0.
REQ-038 abort asserted in second ON cycle -> IDLE next cycle, i_out=0, core_rst=1, no done, spike_cnt retained.
REQ-039 rst=0 during OFF -> outputs at reset values immediately (before next edge); new start after release runs REQ-034 timing.

Source files
------------

// File: rtl/fhn_stim_sequencer.sv
// rtl/fhn_stim_sequencer.sv - stimulus pulse-train sequencer and spike counter for an FHN neuron core
module fhn_stim_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int NP_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic signed [DATA_W-1:0] amp,
    input  logic        [CNT_W-1:0]  settle_len,
    input  logic        [CNT_W-1:0]  on_len,
    input  logic        [CNT_W-1:0]  off_len,
    input  logic        [NP_W-1:0]   n_pulses,
    input  logic signed [DATA_W-1:0] v_th_hi,
    input  logic signed [DATA_W-1:0] v_th_lo,
    input  logic signed [DATA_W-1:0] v,
    output logic signed [DATA_W-1:0] i_out,
    output logic                     core_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     spike,
    output logic        [CNT_W-1:0]  spike_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ON,
        ST_OFF,
        ST_FIN
    } state_t;

    state_t                   r_state;
    logic        [CNT_W-1:0]  r_phase_cnt;
    logic        [NP_W-1:0]   r_pulse_cnt;
    logic signed [DATA_W-1:0] r_amp;
    logic        [CNT_W-1:0]  r_on_len;
    logic        [CNT_W-1:0]  r_off_len;
    logic        [NP_W-1:0]   r_n_pulses;
    logic signed [DATA_W-1:0] r_th_hi;
    logic signed [DATA_W-1:0] r_th_lo;
    logic                     r_armed;
    logic signed [DATA_W-1:0] r_i_out;
    logic                     r_core_rst;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_spike;
    logic        [CNT_W-1:0]  r_spike_cnt;

    logic w_det_active;
    logic w_hit;
    logic w_rearm;

    // A zero-length phase still occupies one cycle, so the down-counter loads len-1 clamped at 0.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    // The abort cycle is excluded so an aborted run keeps the count it had.
    assign w_det_active = ((r_state == ST_SETTLE) || (r_state == ST_ON) || (r_state == ST_OFF))
                          && !abort;
    assign w_hit        = r_armed && (v >= r_th_hi);
    assign w_rearm      = !r_armed && (v <= r_th_lo);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_phase_cnt <= '0;
            r_pulse_cnt <= '0;
            r_amp       <= '0;
            r_on_len    <= '0;
            r_off_len   <= '0;
            r_n_pulses  <= '0;
            r_th_hi     <= '0;
            r_th_lo     <= '0;
            r_armed     <= 1'b1;
            r_i_out     <= '0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_spike     <= 1'b0;
            r_spike_cnt <= '0;
        end else begin
            r_done  <= 1'b0;
            r_spike <= 1'b0;

            if (w_det_active) begin
                if (w_hit) begin
                    r_spike <= 1'b1;
                    r_armed <= 1'b0;
                    if (r_spike_cnt != '1) begin
                        r_spike_cnt <= r_spike_cnt + 1'b1;
                    end
                end else if (w_rearm) begin
                    r_armed <= 1'b1;
                end
            end

            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_amp       <= amp;
                    r_on_len    <= on_len;
                    r_off_len   <= off_len;
                    r_n_pulses  <= n_pulses;
                    r_th_hi     <= v_th_hi;
                    r_th_lo     <= v_th_lo;
                    r_spike_cnt <= '0;
                    r_pulse_cnt <= '0;
                    r_armed     <= 1'b1;
                    if (n_pulses == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state     <= ST_SETTLE;
                        r_phase_cnt <= f_load(settle_len);
                        r_core_rst  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_i_out     <= '0;
                    end
                end
            end else if (abort) begin
                r_state    <= ST_IDLE;
                r_i_out    <= '0;
                r_core_rst <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (r_phase_cnt == '0) begin
                            r_state     <= ST_ON;
                            r_phase_cnt <= f_load(r_on_len);
                            r_i_out     <= r_amp;
                        end else begin
                            r_phase_cnt <= r_phase_cnt - 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (r_phase_cnt == '0) begin
                            r_state     <= ST_OFF;
                            r_phase_cnt <= f_load(r_off_len);
                            r_pulse_cnt <= r_pulse_cnt + 1'b1;
                            r_i_out     <= '0;
                        end else begin
                            r_phase_cnt <= r_phase_cnt - 1'b1;
                        end
                    end
                    ST_OFF: begin
                        if (r_phase_cnt == '0) begin
                            if (r_pulse_cnt == r_n_pulses) begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= ST_ON;
                                r_phase_cnt <= f_load(r_on_len);
                                r_i_out     <= r_amp;
                            end
                        end else begin
                            r_phase_cnt <= r_phase_cnt - 1'b1;
                        end
                    end
                    ST_FIN: begin
                        r_state    <= ST_IDLE;
                        r_core_rst <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_i_out    <= '0;
                        r_core_rst <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i_out     = r_i_out;
    assign core_rst  = r_core_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign spike     = r_spike;
    assign spike_cnt = r_spike_cnt;

endmodule
